// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Sequences a single load or store through a bus-based datapath. A start
//   pulse in IDLE latches the instruction and checks it. A valid access then
//   walks through the address, MAR, data and wait phases. An invalid one goes
//   straight to ERR, which emits a one-cycle err pulse.
//   Every output is a Moore decode of the present state and the latched
//   instruction.
//
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   start           : begin an access (sampled in IDLE only)
//   instr           : {opcode[3:0], param1 (data reg), param2 (address reg)}
//   MFC             : memory function complete (looked at only in wait states)
//   PC_inc .. MDR_EN_write : datapath strobes; mem_RW=1 means read
//   reg_out, reg_in : one-hot bus drive / bus load enables (G0,P0,G1,G2,G3,P1)
//   busy            : high in every state except IDLE
//   done, err       : one-cycle completion / rejection-or-timeout pulses
module mem_access_ctrl #(
  parameter int           INSTR_W   = 16,
  parameter int           REG_SEL_W = 6,
  parameter int           NUM_REGS  = 6,
  parameter logic [3:0]   OP_LOAD   = 4'b0100,
  parameter logic [3:0]   OP_STORE  = 4'b0011,
  parameter int           TIMEOUT   = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [INSTR_W-1:0]  instr,
  input  logic                MFC,
  output logic                PC_inc,
  output logic                MAR_EN,
  output logic                mem_EN,
  output logic                mem_RW,
  output logic                MDR_EN_read,
  output logic                MDR_out,
  output logic                MDR_EN_write,
  output logic [NUM_REGS-1:0] reg_out,
  output logic [NUM_REGS-1:0] reg_in,
  output logic                busy,
  output logic                done,
  output logic                err
);

  if ((INSTR_W < 4 + 2*REG_SEL_W) || (NUM_REGS > 2**REG_SEL_W)) begin : g_bad_params
    $error("mem_access_ctrl: instruction too narrow or too many registers");
  end

  // The counter only has to hold values up to TIMEOUT. With TIMEOUT=0 it is
  // never compared, so one bit is enough.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // One extra bit, so the comparison also works when NUM_REGS == 2**REG_SEL_W.
  localparam logic [REG_SEL_W:0] NUM_REGS_X = (REG_SEL_W+1)'(NUM_REGS);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_MAR, S_ST_DATA, S_ST_WAIT,
    S_LD_WAIT, S_LD_CAP, S_LD_WB, S_DONE, S_ERR
  } state_t;

  state_t               state_q, state_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     cnt_inc;
  logic                 timed_out;

  // Fields of the incoming instruction; used only for the accept/reject check.
  logic [3:0]           op_in;
  logic [REG_SEL_W-1:0] p1_in, p2_in;
  logic                 instr_ok;

  // Fields of the latched instruction; these drive all outputs.
  logic [3:0]           op_q;
  logic [REG_SEL_W-1:0] p1_q, p2_q;
  logic                 is_store_q;
  logic [NUM_REGS-1:0]  sel1, sel2;

  assign op_in = instr[INSTR_W-1 -: 4];
  assign p1_in = instr[INSTR_W-5 -: REG_SEL_W];
  assign p2_in = instr[REG_SEL_W-1:0];
  assign instr_ok = ((op_in == OP_LOAD) || (op_in == OP_STORE)) &&
                    ({1'b0, p1_in} < NUM_REGS_X) && ({1'b0, p2_in} < NUM_REGS_X);

  assign op_q       = instr_q[INSTR_W-1 -: 4];
  assign p1_q       = instr_q[INSTR_W-5 -: REG_SEL_W];
  assign p2_q       = instr_q[REG_SEL_W-1:0];
  assign is_store_q = (op_q == OP_STORE);

  // One-hot decode of the two register selects.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_sel
    assign sel1[gi] = (p1_q == REG_SEL_W'(gi));
    assign sel2[gi] = (p2_q == REG_SEL_W'(gi));
  end

  assign cnt_inc = cnt_q + 1'b1;
  // This is the last wait cycle that is allowed. MFC is checked before this
  // signal, so a completion in the same cycle still counts as success.
  assign timed_out = (TIMEOUT > 0) && (cnt_inc == CNT_W'(TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      instr_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: if (start) begin
        instr_d = instr;
        state_d = instr_ok ? S_ADDR : S_ERR;
      end
      S_ADDR:    state_d = S_MAR;
      S_MAR: begin
        cnt_d   = '0;
        state_d = is_store_q ? S_ST_DATA : S_LD_WAIT;
      end
      S_ST_DATA: begin
        cnt_d   = '0;
        state_d = S_ST_WAIT;
      end
      S_ST_WAIT, S_LD_WAIT: begin
        if (MFC) begin
          state_d = (state_q == S_ST_WAIT) ? S_DONE : S_LD_CAP;
        end else begin
          cnt_d = cnt_inc;
          if (timed_out) state_d = S_ERR;
        end
      end
      S_LD_CAP:  state_d = S_LD_WB;
      S_LD_WB:   state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      S_ERR:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    PC_inc       = 1'b0;
    MAR_EN       = 1'b0;
    mem_EN       = 1'b0;
    mem_RW       = 1'b0;
    MDR_EN_read  = 1'b0;
    MDR_out      = 1'b0;
    MDR_EN_write = 1'b0;
    reg_out      = '0;
    reg_in       = '0;
    done         = 1'b0;
    err          = 1'b0;
    busy         = (state_q != S_IDLE);
    unique case (state_q)
      S_ADDR:    begin reg_out = sel2; PC_inc = 1'b1; end
      S_MAR:     begin reg_out = sel2; MAR_EN = 1'b1; end
      S_ST_DATA: begin reg_out = sel1; MDR_EN_write = 1'b1; end
      S_ST_WAIT: begin mem_EN = 1'b1; end
      S_LD_WAIT: begin mem_EN = 1'b1; mem_RW = 1'b1; end
      S_LD_CAP:  begin mem_EN = 1'b1; mem_RW = 1'b1; MDR_EN_read = 1'b1; end
      S_LD_WB:   begin MDR_out = 1'b1; reg_in = sel1; end
      S_DONE:    done = 1'b1;
      S_ERR:     err = 1'b1;
      default:   ;
    endcase
  end

endmodule
